// File: rtl/vec_issue_pkg.sv
// Shared types and constants for the scalar-to-vector issue path.
package vec_issue_pkg;

    localparam int unsigned ENTRY_XLEN = 32;
    localparam logic [6:0]  OPCODE_V   = 7'h57;
    localparam logic [2:0]  F3_CFG     = 3'b111;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] inst;
        logic [ENTRY_XLEN-1:0] rs1;
        logic [ENTRY_XLEN-1:0] rs2;
        logic                  cfg;
    } issue_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_CFG = 1'b1
    } issue_state_e;

    function automatic logic is_opv(input logic [6:0] opcode);
        return opcode == OPCODE_V;
    endfunction

    function automatic logic is_cfg(input logic [2:0] funct3);
        return funct3 == F3_CFG;
    endfunction

endpackage

// File: rtl/vec_issue_if_if.sv
// Bundle of scalar-side offer, co-processor issue and writeback signals.
interface vec_issue_if_if #(
    parameter int XLEN = 32
);
    logic            inst_valid_i;
    logic [XLEN-1:0] inst_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            inst_ready_o;
    logic            is_vec_o;
    logic            vec_valid_o;
    logic [XLEN-1:0] vec_inst_o;
    logic [XLEN-1:0] rs1_o;
    logic [XLEN-1:0] rs2_o;
    logic            vec_ready_i;
    logic            cfg_done_i;
    logic [XLEN-1:0] cfg_vl_i;
    logic            rd_wb_valid_o;
    logic [4:0]      rd_wb_addr_o;
    logic [XLEN-1:0] rd_wb_data_o;
    logic            busy_o;

    // Issue-block view.
    modport slave (
        input  inst_valid_i, inst_i, rs1_i, rs2_i, vec_ready_i, cfg_done_i, cfg_vl_i,
        output inst_ready_o, is_vec_o, vec_valid_o, vec_inst_o, rs1_o, rs2_o,
               rd_wb_valid_o, rd_wb_addr_o, rd_wb_data_o, busy_o
    );

    // Scalar pipeline / co-processor view.
    modport master (
        output inst_valid_i, inst_i, rs1_i, rs2_i, vec_ready_i, cfg_done_i, cfg_vl_i,
        input  inst_ready_o, is_vec_o, vec_valid_o, vec_inst_o, rs1_o, rs2_o,
               rd_wb_valid_o, rd_wb_addr_o, rd_wb_data_o, busy_o
    );
endinterface

// File: rtl/vec_issue_fifo.sv
// Small synchronous FIFO of issue entries; head is visible the cycle after a push.
module vec_issue_fifo
    import vec_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push_i,
    input  issue_entry_t push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output issue_entry_t head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    issue_entry_t  slot_w [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Full is judged on the pre-pop count, so a push into a full FIFO is refused.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = slot_w[rd_ptr_q];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        issue_entry_t slot_q;
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q == PW'(gi))) begin
                slot_q <= push_data_i;
            end
        end
        assign slot_w[gi] = slot_q;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/vec_issue_if.sv
// Scalar-side vector issue: filters OP-V, queues it, and serialises vset* until vl returns.
module vec_issue_if
    import vec_issue_pkg::*;
#(
    parameter int XLEN  = 32,   // must equal ENTRY_XLEN
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    vec_issue_if_if.slave  bus
);
    issue_state_e    state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_vec_q, is_vec_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    issue_entry_t    push_entry;
    issue_entry_t    head;
    logic            full, empty;
    logic            offer_is_v, inst_ready, accept, push, pop;

    assign offer_is_v = is_opv(bus.inst_i[6:0]);
    assign inst_ready = n_rst && (!full || !offer_is_v);
    assign accept     = bus.inst_valid_i && inst_ready;
    assign push       = accept && offer_is_v;
    assign pop        = (state_q == RUN) && !empty && bus.vec_ready_i;

    assign push_entry = '{inst: bus.inst_i, rs1: bus.rs1_i, rs2: bus.rs2_i,
                          cfg: is_cfg(bus.inst_i[14:12])};

    vec_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= RUN;
            rd_q       <= '0;
            is_vec_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            is_vec_q   <= is_vec_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        is_vec_d   = accept ? offer_is_v : is_vec_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        unique case (state_q)
            RUN: begin
                if (pop && head.cfg) begin
                    rd_d    = head.inst[11:7];
                    state_d = WAIT_CFG;
                end
            end
            WAIT_CFG: begin
                // x0 destination: finish the config without a writeback strobe.
                if (bus.cfg_done_i) begin
                    state_d = RUN;
                    if (rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = rd_q;
                        wb_data_d  = bus.cfg_vl_i;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.inst_ready_o  = inst_ready;
        bus.is_vec_o      = is_vec_q;
        bus.vec_valid_o   = (state_q == RUN) && !empty;
        bus.vec_inst_o    = empty ? '0 : head.inst;
        bus.rs1_o         = empty ? '0 : head.rs1;
        bus.rs2_o         = empty ? '0 : head.rs2;
        bus.rd_wb_valid_o = wb_valid_q;
        bus.rd_wb_addr_o  = wb_addr_q;
        bus.rd_wb_data_o  = wb_data_q;
        bus.busy_o        = !empty || (state_q != RUN);
    end
endmodule

// File: tb/tb_vec_issue_if.sv
// Self-checking bench for vec_issue_if: vector table, directed sequences and an issue scoreboard.
module tb_vec_issue_if;
    localparam logic [31:0] VADD     = 32'h02008057;
    localparam logic [31:0] VSETVLI0 = 32'h01007057;
    localparam logic [31:0] VSETIVLI = 32'hc1087157;
    localparam logic [31:0] VSETVL   = 32'h8030f157;
    localparam logic [31:0] ADDI     = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic        exp_ready;
        logic        exp_is_vec;
    } vec_t;

    logic clk;
    logic n_rst;
    int   tests = 0;
    int   fails = 0;
    int   pops_seen = 0;
    exp_t sb [$];
    vec_t vecs [6];

    vec_issue_if_if #(.XLEN(32)) bus ();

    vec_issue_if #(.XLEN(32), .DEPTH(4)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %b", name, act);
        end
    endtask

    // Issue scoreboard: expectation pushed on accepted OP-V offer, compared on handshake.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.vec_valid_o && bus.vec_ready_i) begin
                pops_seen++;
                if (sb.size() == 0) begin
                    check1("sb_unexpected_issue", bus.vec_valid_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check32("sb_inst", bus.vec_inst_o, e.inst);
                    check32("sb_rs1", bus.rs1_o, e.rs1);
                    check32("sb_rs2", bus.rs2_o, e.rs2);
                end
            end
            if (bus.inst_valid_i && bus.inst_ready_o && bus.inst_i[6:0] == 7'h57) begin
                sb.push_back('{inst: bus.inst_i, rs1: bus.rs1_i, rs2: bus.rs2_i});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = i;
        bus.rs1_i        = r1;
        bus.rs2_i        = r2;
    endtask

    task automatic idle();
        bus.inst_valid_i = 1'b0;
        bus.inst_i       = '0;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_inst_ready"}, bus.inst_ready_o, 1'b0);
        check1({tag, "_is_vec"}, bus.is_vec_o, 1'b0);
        check1({tag, "_vec_valid"}, bus.vec_valid_o, 1'b0);
        check1({tag, "_busy"}, bus.busy_o, 1'b0);
        check1({tag, "_wb_valid"}, bus.rd_wb_valid_o, 1'b0);
        check32({tag, "_vec_inst"}, bus.vec_inst_o, 32'h0);
        check32({tag, "_rs1"}, bus.rs1_o, 32'h0);
        check32({tag, "_rs2"}, bus.rs2_o, 32'h0);
        check32({tag, "_wb_addr"}, 32'(bus.rd_wb_addr_o), 32'h0);
        check32({tag, "_wb_data"}, bus.rd_wb_data_o, 32'h0);
    endtask

    initial begin
        int pops_before;
        bit drained;

        vecs[0] = '{inst: VADD,          exp_ready: 1'b1, exp_is_vec: 1'b1};
        vecs[1] = '{inst: ADDI,          exp_ready: 1'b1, exp_is_vec: 1'b0};
        vecs[2] = '{inst: 32'h5e0030d7,  exp_ready: 1'b1, exp_is_vec: 1'b1};
        vecs[3] = '{inst: 32'h0000006f,  exp_ready: 1'b1, exp_is_vec: 1'b0};
        vecs[4] = '{inst: 32'h12345657,  exp_ready: 1'b1, exp_is_vec: 1'b1};
        vecs[5] = '{inst: 32'h00002003,  exp_ready: 1'b1, exp_is_vec: 1'b0};

        n_rst           = 1'b0;
        bus.vec_ready_i = 1'b0;
        bus.cfg_done_i  = 1'b0;
        bus.cfg_vl_i    = '0;
        offer(VADD, 32'd1, 32'd2);
        repeat (2) step();
        at_neg();
        check_reset_outputs("reset");
        step();
        idle();
        n_rst = 1'b1;

        // Plain vadd: issued the cycle after acceptance, popped on the next edge.
        bus.vec_ready_i = 1'b1;
        offer(VADD, 32'd5, 32'd7);
        at_neg();
        check1("t1_inst_ready", bus.inst_ready_o, 1'b1);
        step();
        idle();
        at_neg();
        check1("t1_vec_valid", bus.vec_valid_o, 1'b1);
        check32("t1_vec_inst", bus.vec_inst_o, VADD);
        check32("t1_rs1", bus.rs1_o, 32'd5);
        check32("t1_rs2", bus.rs2_o, 32'd7);
        check1("t1_is_vec", bus.is_vec_o, 1'b1);
        step();
        at_neg();
        check1("t1_popped", bus.vec_valid_o, 1'b0);
        check1("t1_no_wb", bus.rd_wb_valid_o, 1'b0);
        check1("t1_busy", bus.busy_o, 1'b0);
        step();

        // vsetvli x0 then vadd back-to-back: vadd held until cfg_done, no writeback.
        offer(VSETVLI0, 32'd0, 32'd0);
        at_neg();
        check1("t2_cfg_ready", bus.inst_ready_o, 1'b1);
        step();
        offer(VADD, 32'd11, 32'd12);
        at_neg();
        check32("t2_cfg_issue", bus.vec_inst_o, VSETVLI0);
        step();
        idle();
        at_neg();
        check1("t2_hold_a", bus.vec_valid_o, 1'b0);
        check1("t2_busy", bus.busy_o, 1'b1);
        step();
        at_neg();
        check1("t2_hold_b", bus.vec_valid_o, 1'b0);
        step();
        bus.cfg_done_i = 1'b1;
        bus.cfg_vl_i   = 32'd16;
        at_neg();
        check1("t2_hold_done_cycle", bus.vec_valid_o, 1'b0);
        step();
        bus.cfg_done_i = 1'b0;
        at_neg();
        check1("t2_issue_after_cfg", bus.vec_valid_o, 1'b1);
        check32("t2_vadd_inst", bus.vec_inst_o, VADD);
        check1("t2_no_wb_rd0", bus.rd_wb_valid_o, 1'b0);
        step();
        at_neg();
        check1("t2_idle", bus.busy_o, 1'b0);
        step();

        // vsetivli x2: cfg_done three cycles after issue, one-cycle writeback of vl=8.
        offer(VSETIVLI, 32'd0, 32'd0);
        step();
        idle();
        at_neg();
        check1("t3_issue", bus.vec_valid_o, 1'b1);
        step();
        at_neg();
        check1("t3_wait_valid", bus.vec_valid_o, 1'b0);
        check1("t3_wait_busy", bus.busy_o, 1'b1);
        check1("t3_no_early_wb", bus.rd_wb_valid_o, 1'b0);
        step();
        step();
        bus.cfg_done_i = 1'b1;
        bus.cfg_vl_i   = 32'd8;
        step();
        bus.cfg_done_i = 1'b0;
        at_neg();
        check1("t3_wb_valid", bus.rd_wb_valid_o, 1'b1);
        check32("t3_wb_addr", 32'(bus.rd_wb_addr_o), 32'd2);
        check32("t3_wb_data", bus.rd_wb_data_o, 32'd8);
        step();
        at_neg();
        check1("t3_wb_one_cycle", bus.rd_wb_valid_o, 1'b0);
        check1("t3_idle", bus.busy_o, 1'b0);
        step();

        // vsetvl x2 with register operands.
        offer(VSETVL, 32'd15, 32'h10);
        step();
        idle();
        at_neg();
        check1("t4_issue", bus.vec_valid_o, 1'b1);
        check32("t4_rs1", bus.rs1_o, 32'd15);
        check32("t4_rs2", bus.rs2_o, 32'd16);
        step();
        step();
        bus.cfg_done_i = 1'b1;
        bus.cfg_vl_i   = 32'h20;
        step();
        bus.cfg_done_i = 1'b0;
        at_neg();
        check1("t4_wb_valid", bus.rd_wb_valid_o, 1'b1);
        check32("t4_wb_addr", 32'(bus.rd_wb_addr_o), 32'd2);
        check32("t4_wb_data", bus.rd_wb_data_o, 32'h20);
        step();

        // Table of single offers with the co-processor always ready.
        for (int v = 0; v < 6; v++) begin
            offer(vecs[v].inst, 32'(v), 32'(v + 100));
            at_neg();
            check1($sformatf("tbl%0d_ready", v), bus.inst_ready_o, vecs[v].exp_ready);
            step();
            idle();
            at_neg();
            check1($sformatf("tbl%0d_is_vec", v), bus.is_vec_o, vecs[v].exp_is_vec);
            step();
        end

        // Fill with ready low: 4 accepted, 5th refused, head stable; non-OP-V still accepted.
        bus.vec_ready_i = 1'b0;
        pops_before = pops_seen;
        for (int k = 0; k < 5; k++) begin
            offer(VADD, 32'h100 + 32'(k), 32'h200 + 32'(k));
            at_neg();
            check1($sformatf("t5_ready%0d", k), bus.inst_ready_o, (k < 4));
            step();
        end
        idle();
        at_neg();
        check1("t5_valid_held", bus.vec_valid_o, 1'b1);
        check32("t5_head_rs1", bus.rs1_o, 32'h100);
        step();
        at_neg();
        check32("t5_head_stable", bus.rs1_o, 32'h100);
        check32("t5_inst_stable", bus.vec_inst_o, VADD);
        offer(ADDI, 32'd3, 32'd4);
        at_neg();
        check1("t5_nonv_ready", bus.inst_ready_o, 1'b1);
        step();
        idle();
        at_neg();
        check1("t5_nonv_is_vec", bus.is_vec_o, 1'b0);
        bus.vec_ready_i = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            step();
            at_neg();
            if (!bus.vec_valid_o) drained = 1'b1;
        end
        check1("t5_drained", bus.vec_valid_o, 1'b0);
        check32("t5_drain_count", 32'(pops_seen - pops_before), 32'd4);
        step();

        // Reset while waiting for config with two entries queued.
        offer(VSETIVLI, 32'd0, 32'd0);
        step();
        idle();
        at_neg();
        step();
        offer(VADD, 32'd7, 32'd7);
        step();
        offer(VADD, 32'd8, 32'd8);
        step();
        idle();
        at_neg();
        check1("t6_pre_wait", bus.vec_valid_o, 1'b0);
        check1("t6_pre_busy", bus.busy_o, 1'b1);
        step();
        n_rst = 1'b0;
        step();
        sb.delete();
        at_neg();
        check_reset_outputs("t6_rst");
        step();
        n_rst          = 1'b1;
        bus.cfg_done_i = 1'b1;
        bus.cfg_vl_i   = 32'd9;
        step();
        bus.cfg_done_i = 1'b0;
        at_neg();
        check1("t6_no_wb", bus.rd_wb_valid_o, 1'b0);
        check1("t6_no_issue", bus.vec_valid_o, 1'b0);
        check1("t6_idle", bus.busy_o, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
